axi4_wr_slave: RTL and testbench
================================

Name: axi4_wr_slave

Overview:
AXI4 write-side slave that sits downstream of axi4_if and consumes its AW, W and B channels. It accepts one burst at a time, generates per-beat byte addresses for FIXED, INCR and WRAP bursts, and drives a simple registered memory write port. It returns a single write response per burst.

Parameters:
ID_WIDTH, 4, width of AWID/BID
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data bus width; legal values 32/64/128; strobe width is DATA_WIDTH/8

Ports:
clock  in  1  system clock, rising edge
ARESETn  in  1  asynchronous active-low reset
AWID  in  ID_WIDTH  write burst ID
AWADDR  in  ADDR_WIDTH  burst start byte address
AWLEN  in  8  beats minus 1
AWSIZE  in  3  log2 bytes per beat
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
AWVALID  in  1  address valid
AWREADY  out  1  address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte strobes
WLAST  in  1  last beat marker
WVALID  in  1  data valid
WREADY  out  1  data ready
BID  out  ID_WIDTH  response ID, equals captured AWID
BRESP  out  2  00 OKAY, 10 SLVERR
BVALID  out  1  response valid
BREADY  in  1  response ready
mem_we  out  1  one-cycle write pulse per accepted beat
mem_addr  out  ADDR_WIDTH  beat byte address
mem_wdata  out  DATA_WIDTH  registered WDATA
mem_wstrb  out  DATA_WIDTH/8  registered WSTRB

Behaviour:
- Reset (async, ARESETn low): FSM goes to IDLE. AWREADY=1, WREADY=0, BVALID=0, BRESP=00, BID=0, mem_we=0, mem_addr/mem_wdata/mem_wstrb=0.
- FSM states:
  - IDLE: AWREADY=1. On AWVALID the block captures ID, addr, len, size and burst, clears the beat counter and the error flag, and moves to DATA. AWREADY drops the next cycle.
  - DATA: WREADY=1. Each WVALID&WREADY cycle is a beat. The next cycle outputs mem_we=1 with that beat's address, data and strobes (latency 1). When beat count equals len, the block moves to RESP and WREADY drops the next cycle.
  - RESP: BVALID=1, with BID and BRESP held stable until BREADY. On BVALID&BREADY the block returns to IDLE, with AWREADY=1 the following cycle. No AW is accepted outside IDLE.
- Address update after each beat, with step = 1<<size:
  - FIXED: address unchanged.
  - INCR: address += step, modulo 2^ADDR_WIDTH.
  - WRAP: boundary = (len+1)*step. Address wraps to the aligned base (addr & ~(boundary-1)) when it reaches base+boundary.
- SLVERR conditions, checked at AW capture:
  - AWBURST=11.
  - AWSIZE > log2(DATA_WIDTH/8).
  - WRAP with len not in {1,3,7,15}.
  - WRAP with an unaligned start address.
  - Any of these suppresses mem_we for the whole burst; beats are still accepted and counted.
- WLAST mismatch (WLAST=1 before the final beat, or 0 on the final beat): BRESP=10. Writes are not suppressed, and the burst still ends on the len count.
- WVALID low in DATA: the block stalls with no mem_we. Holding BREADY low keeps the FSM in RESP indefinitely.
- AWLEN=0: single beat; DATA to RESP after one beat.

Optional Feature:
AXI4_WR_SLAVE_4KB_CHECK_EN
- Defined: an INCR burst whose last byte address differs from its start in bits [ADDR_WIDTH-1:12] is flagged SLVERR at capture, and all its mem_we pulses are suppressed.
- Undefined: no check; INCR addresses cross 4KB freely.

Test Plan:
1. INCR, AWADDR=0x100, AWLEN=3, AWSIZE=2, AWID=5, four beats with WLAST on beat 4 -> mem_we at addresses 0x100/0x104/0x108/0x10C, one cycle after each beat; BID=5, BRESP=00.
2. WRAP, AWADDR=0x38, AWLEN=3, AWSIZE=2 -> addresses 0x38, 0x3C, 0x30, 0x34; BRESP=00.
3. FIXED, AWADDR=0x20, AWLEN=2, with WVALID deasserted for 2 cycles mid-burst -> three mem_we pulses, all at 0x20, none during the stall; BRESP=00.
4. AWBURST=11, AWLEN=1 -> both beats accepted, no mem_we, BRESP=10; with BREADY held low 5 cycles, BVALID stays high and AWREADY stays low until the handshake.
5. INCR, AWLEN=3, with WLAST asserted on beat 2 -> four writes performed, BRESP=10.
6. ARESETn pulsed low after beat 2 of an AWLEN=7 burst -> all outputs return to reset values immediately, AWREADY=1, and a new burst completes normally.

Source files
------------

// File: rtl/axi4_wr_slave_if.sv
// AXI4 write-channel bundle (AW, W, B) shared by a write master and axi4_wr_slave.
// Signal names follow the AXI4 channel names; widths track the slave parameters.
interface axi4_wr_slave_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     AWID;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;
  logic [ID_WIDTH-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WDATA, WSTRB, WLAST, WVALID, BREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID
  );
endinterface

// File: rtl/axi4_wr_slave.sv
// Single-outstanding AXI4 write slave: FIXED/INCR/WRAP beat addressing, registered memory write port.
// Define AXI4_WR_SLAVE_4KB_CHECK_EN to flag INCR bursts that cross a 4KB page as SLVERR.
module axi4_wr_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    ARESETn,
  axi4_wr_slave_if.slave          axi,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  logic [1:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [7:0]            cnt_q;
  logic                  cap_err_q;
  logic                  last_err_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [STRB_WIDTH-1:0] mem_wstrb_q;

  logic                  aw_fire, w_fire, b_fire, final_beat;
  logic                  aw_err;
  logic [ADDR_WIDTH-1:0] aw_step;
  logic [ADDR_WIDTH-1:0] step, wrap_bytes, wrap_base, incr_addr, next_addr;

  assign aw_fire    = axi.AWVALID && (state_q == IDLE);
  assign w_fire     = axi.WVALID  && (state_q == DATA);
  assign b_fire     = axi.BREADY  && (state_q == RESP);
  assign final_beat = (cnt_q == len_q);

  // Protocol violations are decided once, from the AW beat, and govern the whole burst.
  always_comb begin
    aw_step = ADDR_ONE << axi.AWSIZE;
    aw_err  = (axi.AWBURST == BURST_RSVD) || (axi.AWSIZE > MAX_SIZE) ||
              ((axi.AWBURST == BURST_WRAP) &&
               (!(axi.AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                ((axi.AWADDR & (aw_step - ADDR_ONE)) != '0)));
`ifdef AXI4_WR_SLAVE_4KB_CHECK_EN
    begin
      logic [ADDR_WIDTH-1:0] aw_last;
      aw_last = (axi.AWADDR & ~(aw_step - ADDR_ONE)) +
                ((ADDR_WIDTH'(axi.AWLEN) + ADDR_ONE) << axi.AWSIZE) - ADDR_ONE;
      if ((axi.AWBURST == BURST_INCR) &&
          (aw_last[ADDR_WIDTH-1:12] != axi.AWADDR[ADDR_WIDTH-1:12]))
        aw_err = 1'b1;
    end
`else
    // No page check: INCR addresses roll across 4KB boundaries untouched.
`endif
  end

  // WRAP returns to the aligned base once the incremented address hits the window top.
  always_comb begin
    step       = ADDR_ONE << size_q;
    wrap_bytes = (ADDR_WIDTH'(len_q) + ADDR_ONE) << size_q;
    wrap_base  = addr_q & ~(wrap_bytes - ADDR_ONE);
    incr_addr  = addr_q + step;
    unique case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (incr_addr == wrap_base + wrap_bytes) ? wrap_base : incr_addr;
      default:     next_addr = incr_addr;
    endcase
  end

  // NOTE: every signal driven in always_comb gets a value on every path, or a latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_fire) state_d = DATA;
      DATA:    if (w_fire && final_beat) state_d = RESP;
      RESP:    if (b_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      cap_err_q   <= 1'b0;
      last_err_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= w_fire && !cap_err_q;
      if (aw_fire) begin
        id_q       <= axi.AWID;
        addr_q     <= axi.AWADDR;
        len_q      <= axi.AWLEN;
        size_q     <= axi.AWSIZE;
        burst_q    <= axi.AWBURST;
        cnt_q      <= '0;
        cap_err_q  <= aw_err;
        last_err_q <= 1'b0;
      end
      if (w_fire) begin
        cnt_q       <= cnt_q + 8'd1;
        addr_q      <= next_addr;
        last_err_q  <= last_err_q || (axi.WLAST != final_beat);
        mem_addr_q  <= addr_q;
        mem_wdata_q <= axi.WDATA;
        mem_wstrb_q <= axi.WSTRB;
      end
    end
  end

  assign axi.AWREADY = (state_q == IDLE);
  assign axi.WREADY  = (state_q == DATA);
  assign axi.BVALID  = (state_q == RESP);
  assign axi.BID     = id_q;
  assign axi.BRESP   = ((state_q == RESP) && (cap_err_q || last_err_q)) ? 2'b10 : 2'b00;

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
endmodule

// File: tb/tb_axi4_wr_slave.sv
// Scoreboard bench for axi4_wr_slave: directed bursts then randomized bursts against a burst-level model.
// Expected writes and responses are queued by the driver and consumed by an independent monitor.
module tb_axi4_wr_slave;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;
  localparam logic [1:0] RSVD  = 2'b11;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    int            cyc;
  } wr_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_t;

  logic          clock = 1'b0;
  logic          ARESETn = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;

  axi4_wr_slave_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_wr_slave #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock     (clock),
    .ARESETn   (ARESETn),
    .axi       (bus.slave),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb)
  );

  always #5 clock = ~clock;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  wr_t exp_wr[$];
  b_t  exp_b[$];
  wr_t mon_w;
  b_t  mon_b;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic give_up(input string what);
    checks++;
    errors++;
    $display("FAIL timeout waiting for %s (t=%0t)", what, $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [AW-1:0] step_of(input logic [2:0] size);
    return AW'(1) << size;
  endfunction

  function automatic bit model_slverr(input logic [AW-1:0] addr, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
    logic [AW-1:0] st;
    bit e;
    st = step_of(size);
    e = (burst == RSVD) || (int'(size) > $clog2(SW));
    if (burst == WRAP && !(len == 1 || len == 3 || len == 7 || len == 15)) e = 1;
    if (burst == WRAP && (addr % st) != 0) e = 1;
`ifdef AXI4_WR_SLAVE_4KB_CHECK_EN
    if (burst == INCR) begin
      logic [AW-1:0] first, last;
      first = addr - (addr % st);
      last  = first + (AW'(len) + 1) * st - 1;
      if ((last >> 12) != (addr >> 12)) e = 1;
    end
`endif
    return e;
  endfunction

  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] addr, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst,
                                               input int beat);
    logic [AW-1:0] st, bnd, base;
    st = step_of(size);
    case (burst)
      FIXED: return addr;
      WRAP: begin
        bnd  = (AW'(len) + 1) * st;
        base = addr - (addr % bnd);
        return base + ((addr - base + AW'(beat) * st) % bnd);
      end
      default: return addr + AW'(beat) * st;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (ARESETn) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) check("unexpected_mem_we", 1, 0);
        else begin
          mon_w = exp_wr.pop_front();
          check("mem_addr", mem_addr, mon_w.addr);
          check("mem_wdata", mem_wdata, mon_w.data);
          check("mem_wstrb", mem_wstrb, mon_w.strb);
          check("mem_we_cycle", cyc, mon_w.cyc);
        end
      end
      if (bus.BVALID && bus.BREADY) begin
        if (exp_b.size() == 0) check("unexpected_b", 1, 0);
        else begin
          mon_b = exp_b.pop_front();
          check("bid", bus.BID, mon_b.id);
          check("bresp", bus.BRESP, mon_b.resp);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic check_reset_outputs();
    check("rst_awready", bus.AWREADY, 1);
    check("rst_wready", bus.WREADY, 0);
    check("rst_bvalid", bus.BVALID, 0);
    check("rst_bresp", bus.BRESP, 0);
    check("rst_bid", bus.BID, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
  endtask

  task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(posedge clock); #1;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst;
    bus.AWVALID = 1'b1;
    do begin
      @(negedge clock);
      if (++n > 100) give_up("AWREADY");
    end while (!bus.AWREADY);
    @(posedge clock); #1;
    bus.AWVALID = 1'b0;
  endtask

  task automatic get_b(input int stall);
    int n = 0;
    repeat (stall) begin
      @(negedge clock);
      check("bvalid_held", bus.BVALID, 1);
      check("awready_low_in_resp", bus.AWREADY, 0);
      @(posedge clock); #1;
    end
    bus.BREADY = 1'b1;
    do begin
      @(negedge clock);
      if (++n > 100) give_up("BVALID");
    end while (!bus.BVALID);
    @(posedge clock); #1;
    bus.BREADY = 1'b0;
    @(negedge clock);
    check("awready_after_b", bus.AWREADY, 1);
    check("bvalid_after_b", bus.BVALID, 0);
  endtask

  task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int bad_beat,
                           input int gap_beat, input int gap_len, input int bstall, input int abort_at);
    bit  err, wl_err;
    logic last;
    wr_t w;
    b_t  b;
    err = model_slverr(addr, len, size, burst);
    wl_err = 0;
    send_aw(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      int n = 0;
      if (i == abort_at) begin
        ARESETn = 1'b0;
        #1;
        check_reset_outputs();
        exp_wr.delete();
        repeat (2) @(posedge clock);
        #1 ARESETn = 1'b1;
        return;
      end
      if (i == gap_beat) repeat (gap_len) begin @(posedge clock); #1; end
      last = (i == int'(len));
      if (i == bad_beat) begin last = !last; wl_err = 1; end
      bus.WDATA = $urandom; bus.WSTRB = SW'($urandom); bus.WLAST = last; bus.WVALID = 1'b1;
      do begin
        @(negedge clock);
        if (++n > 100) give_up("WREADY");
      end while (!bus.WREADY);
      if (!err) begin
        w.addr = model_addr(addr, len, size, burst, i);
        w.data = bus.WDATA; w.strb = bus.WSTRB; w.cyc = cyc + 1;
        exp_wr.push_back(w);
      end
      @(posedge clock); #1;
      bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    end
    b.id = id;
    b.resp = (err || wl_err) ? 2'b10 : 2'b00;
    exp_b.push_back(b);
    get_b(bstall);
  endtask

  initial begin
    #1_000_000;
    give_up("end of test (watchdog)");
  end

  initial begin
    logic [AW-1:0] a;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    int            bad, gap;
    bus.AWVALID = 0; bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
    bus.WVALID = 0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 0; bus.BREADY = 0;
    #1 ARESETn = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(posedge clock);
    #1 ARESETn = 1'b1;

    run_burst(4'd5, 32'h100, 8'd3, 3'd2, INCR,  -1, -1, 0, 0, -1);
    run_burst(4'd1, 32'h38,  8'd3, 3'd2, WRAP,  -1, -1, 0, 0, -1);
    run_burst(4'd2, 32'h20,  8'd2, 3'd2, FIXED, -1,  1, 2, 0, -1);
    run_burst(4'd3, 32'h40,  8'd1, 3'd2, RSVD,  -1, -1, 0, 5, -1);
    run_burst(4'd4, 32'h200, 8'd3, 3'd2, INCR,   1, -1, 0, 0, -1);
    run_burst(4'd6, 32'h400, 8'd7, 3'd2, INCR,  -1, -1, 0, 0,  2);
    run_burst(4'd7, 32'h500, 8'd1, 3'd2, INCR,  -1, -1, 0, 1, -1);

    for (int k = 0; k < 40; k++) begin
      burst = ($urandom_range(0, 9) == 0) ? RSVD : 2'($urandom_range(0, 2));
      size  = 3'($urandom_range(0, 3));
      if (burst == WRAP && $urandom_range(0, 4) != 0) len = 8'((2 << $urandom_range(0, 3)) - 1);
      else len = 8'($urandom_range(0, 15));
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[11:0] = 12'hFF0;
      if (burst == WRAP && $urandom_range(0, 4) != 0) a = a & ~(step_of(size) - 1);
      bad = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, int'(len))) : -1;
      gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(len))) : -1;
      run_burst(IW'($urandom), a, len, size, burst, bad, gap, $urandom_range(1, 3),
                $urandom_range(0, 3), -1);
    end

    repeat (3) @(posedge clock);
    check("wr_queue_drained", exp_wr.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
